// File: rtl/debouncer.sv
// Push-button debouncer: two-flop synchronizer followed by a stability-counting FSM.
// Optional macro DEBOUNCER_EDGE_EN adds registered btn_rise / btn_fall pulse outputs.
module debouncer #(
    parameter int DELAY = 1000000,
    parameter int CNT_W = $clog2(DELAY)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_db
`ifdef DEBOUNCER_EDGE_EN
    ,
    output logic btn_rise,
    output logic btn_fall
`endif
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

    logic             sync1_r;
    logic             sync2_r;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             db_r;
    logic             db_s;

    // Two-flop synchronizer for the asynchronous button level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, counter and debounced-level logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        db_s    = db_r;
        case (state_r)
            STABLE_LO: begin
                db_s = 1'b0;
                if (sync2_r) begin
                    state_s = WAIT_HI;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            WAIT_HI: begin
                db_s = 1'b0;
                if (!sync2_r) begin
                    state_s = STABLE_LO;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = STABLE_HI;
                    cnt_s   = CNT_ZERO;
                    db_s    = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            STABLE_HI: begin
                db_s = 1'b1;
                if (!sync2_r) begin
                    state_s = WAIT_LO;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            WAIT_LO: begin
                db_s = 1'b1;
                if (sync2_r) begin
                    state_s = STABLE_HI;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = STABLE_LO;
                    cnt_s   = CNT_ZERO;
                    db_s    = 1'b0;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = STABLE_LO;
                cnt_s   = CNT_ZERO;
                db_s    = 1'b0;
            end
        endcase
    end

    // FSM state, stability counter and registered output level
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= STABLE_LO;
            cnt_r   <= CNT_ZERO;
            db_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            db_r    <= db_s;
        end
    end

    assign btn_db = db_r;

`ifdef DEBOUNCER_EDGE_EN
    logic rise_r;
    logic fall_r;

    // Edge pulses coincide with the edge on which btn_db itself changes
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= db_s & ~db_r;
            fall_r <= ~db_s & db_r;
        end
    end

    assign btn_rise = rise_r;
    assign btn_fall = fall_r;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: hand-derived segment table, glitch and hold
// sequences, then random stimulus against a run-length reference model.
module tb_debouncer;

    localparam int DELAY = 16;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_db;
`ifdef DEBOUNCER_EDGE_EN
    logic btn_rise;
    logic btn_fall;
`endif

    int n_vec   = 0;
    int n_miscmp = 0;
    int cyc     = 0;

    // Reference model: accepted level flips after DELAY consecutive mismatching samples
    logic m_s1, m_s2, m_db, m_rise, m_fall;
    int   m_run;

    debouncer #(.DELAY(DELAY)) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .btn_db (btn_db)
`ifdef DEBOUNCER_EDGE_EN
        ,
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        logic rst;
        int   cycles;
        logic exp_db;
    } seg_t;

    seg_t tbl [0:16];

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0; m_run = 0;
            m_rise = 1'b0; m_fall = 1'b0;
        end else begin
            m_rise = 1'b0; m_fall = 1'b0;
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == DELAY) begin
                    m_db   = ~m_db;
                    m_run  = 0;
                    m_rise = m_db;
                    m_fall = ~m_db;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic tick(input logic b, input logic r);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        cyc++;
        model_step(b, r);
        #1;
        check("btn_db", btn_db, m_db);
`ifdef DEBOUNCER_EDGE_EN
        check("btn_rise", btn_rise, m_rise);
        check("btn_fall", btn_fall, m_fall);
        check("rise_fall_exclusive", btn_rise & btn_fall, 1'b0);
`endif
    endtask

    initial begin
        logic lvl;
        int   len;
        btn_in = 1'b1;
        rst    = 1'b1;
        m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0; m_run = 0;
        m_rise = 1'b0; m_fall = 1'b0;

        // {btn, rst, cycles, btn_db expected after the last cycle}
        tbl = '{
            '{1'b1, 1'b1,  2, 1'b0},   // reset held with button pressed
            '{1'b1, 1'b0, 17, 1'b0},   // clean press: 17 edges still low
            '{1'b1, 1'b0,  1, 1'b1},   // edge 18 accepts
            '{1'b1, 1'b0, 22, 1'b1},
            '{1'b0, 1'b0, 17, 1'b1},   // clean release
            '{1'b0, 1'b0,  1, 1'b0},
            '{1'b1, 1'b0, 15, 1'b0},   // near miss: DELAY-1 high samples
            '{1'b0, 1'b0, 20, 1'b0},
            '{1'b1, 1'b0, 16, 1'b0},   // exactly DELAY high samples
            '{1'b0, 1'b0,  1, 1'b0},
            '{1'b0, 1'b0,  1, 1'b1},
            '{1'b0, 1'b0, 15, 1'b1},
            '{1'b0, 1'b0,  1, 1'b0},
            '{1'b1, 1'b0, 12, 1'b0},   // count reaches 10
            '{1'b1, 1'b1,  1, 1'b0},   // reset mid-count
            '{1'b1, 1'b0, 17, 1'b0},   // full restart
            '{1'b1, 1'b0,  1, 1'b1}
        };

        for (int i = 0; i < 17; i++) begin
            for (int c = 0; c < tbl[i].cycles; c++) begin
                tick(tbl[i].btn, tbl[i].rst);
            end
            check($sformatf("table_seg%0d", i), btn_db, tbl[i].exp_db);
        end

        // Glitch burst from an accepted high level: no excursion reaches DELAY
        lvl = 1'b1;
        for (int t = 0; t < 20; t++) begin
            lvl = ~lvl;
            len = int'($urandom_range(DELAY - 1, 1));
            for (int c = 0; c < len; c++) begin
                tick(lvl, 1'b0);
            end
        end
        check("glitch_burst_hold", btn_db, 1'b1);
        for (int c = 0; c < DELAY + 2; c++) begin
            tick(1'b1, 1'b0);
        end
        check("glitch_burst_settle", btn_db, 1'b1);

        // Long holds of DELAY+1 cycles: each level lands one cycle into the next hold
        for (int c = 0; c < DELAY + 1; c++) tick(1'b0, 1'b0);
        check("long_hold_1", btn_db, 1'b1);
        for (int c = 0; c < DELAY + 1; c++) tick(1'b1, 1'b0);
        check("long_hold_2", btn_db, 1'b0);
        for (int c = 0; c < DELAY + 1; c++) tick(1'b0, 1'b0);
        check("long_hold_3", btn_db, 1'b1);
        for (int c = 0; c < DELAY + 2; c++) tick(1'b0, 1'b0);
        check("long_hold_tail", btn_db, 1'b0);

        // Random levels and hold lengths with occasional reset pulses
        for (int s = 0; s < 300; s++) begin
            lvl = 1'($urandom_range(1, 0));
            len = int'($urandom_range(2 * DELAY, 1));
            for (int c = 0; c < len; c++) begin
                tick(lvl, ($urandom_range(39, 0) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
